// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the integer register file with scoreboard.
//   XLEN_DEF / NREG_DEF / NRD_DEF : default data width, register count and
//                                   read-port count.
//   AW_DEF                        : register address width for the defaults.
//   REG_ZERO                      : index of the hardwired-zero register.
//   addr_t / data_t               : address and data types for the defaults.
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int NRD_DEF  = 2;
    localparam int AW_DEF   = $clog2(NREG_DEF);
    localparam int REG_ZERO = 0;

    typedef logic [AW_DEF-1:0]   addr_t;
    typedef logic [XLEN_DEF-1:0] data_t;

endpackage

// File: rtl/regfile_sb_if.sv
// -----------------------------------------------------------------------------
// regfile_sb_if
// Bundle of read, issue, writeback and collision signals for regfile_sb.
//   master : decode / writeback side (drives addresses, issue, writebacks)
//   slave  : the register file itself
// Signals:
//   rs_addr_i  NRD*AW   read addresses, port k at [k*AW +: AW]
//   rs_data_o  NRD*XLEN read data, port k at [k*XLEN +: XLEN]
//   rs_busy_o  NRD      source register has a pending, not yet visible write
//   issue_*             destination reservation handshake
//   wb0_*               single-cycle ALU writeback
//   wb1_*               load / long-latency writeback
//   collision_o         one-cycle pulse after a same-register dual writeback
// -----------------------------------------------------------------------------
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = NRD_DEF
);
    localparam int AW = $clog2(NREG);

    logic [NRD*AW-1:0]   rs_addr_i;
    logic [NRD*XLEN-1:0] rs_data_o;
    logic [NRD-1:0]      rs_busy_o;

    logic                issue_valid_i;
    logic [AW-1:0]       issue_rd_i;
    logic                issue_ready_o;

    logic                wb0_valid_i;
    logic [AW-1:0]       wb0_addr_i;
    logic [XLEN-1:0]     wb0_data_i;

    logic                wb1_valid_i;
    logic [AW-1:0]       wb1_addr_i;
    logic [XLEN-1:0]     wb1_data_i;

    logic                collision_o;

    modport master (
        output rs_addr_i,
        input  rs_data_o,
        input  rs_busy_o,
        output issue_valid_i,
        output issue_rd_i,
        input  issue_ready_o,
        output wb0_valid_i,
        output wb0_addr_i,
        output wb0_data_i,
        output wb1_valid_i,
        output wb1_addr_i,
        output wb1_data_i,
        input  collision_o
    );

    modport slave (
        input  rs_addr_i,
        output rs_data_o,
        output rs_busy_o,
        input  issue_valid_i,
        input  issue_rd_i,
        output issue_ready_o,
        input  wb0_valid_i,
        input  wb0_addr_i,
        input  wb0_data_i,
        input  wb1_valid_i,
        input  wb1_addr_i,
        input  wb1_data_i,
        output collision_o
    );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
// Busy bit per architectural register. A bit is set when an instruction that
// writes the register issues and cleared when a writeback to it arrives.
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   issue_valid_i      decode wants to issue an instruction writing issue_rd_i
//   issue_rd_i         destination register of that instruction
//   issue_ready_o      destination is free (or being written right now)
//   wb0_valid_i/addr_i ALU writeback
//   wb1_valid_i/addr_i load writeback
//   busy_o             current busy vector (bit 0 is always 0)
// -----------------------------------------------------------------------------
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            issue_valid_i,
    input  logic [AW-1:0]   issue_rd_i,
    output logic            issue_ready_o,
    input  logic            wb0_valid_i,
    input  logic [AW-1:0]   wb0_addr_i,
    input  logic            wb1_valid_i,
    input  logic [AW-1:0]   wb1_addr_i,
    output logic [NREG-1:0] busy_o
);

    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;
    logic            issue_fire;

    // A writeback landing on the destination this cycle frees it, so the
    // issuing instruction need not wait an extra cycle.
    always_comb begin
        issue_ready_o = (issue_rd_i == AW'(REG_ZERO))
                     || !busy_reg[issue_rd_i]
                     || (wb0_valid_i && (wb0_addr_i == issue_rd_i))
                     || (wb1_valid_i && (wb1_addr_i == issue_rd_i));
    end

    assign issue_fire = issue_valid_i && issue_ready_o;

    // Clear first, then set: a new producer issuing in the same cycle as the
    // old producer's writeback must keep the register reserved.
    always_comb begin
        busy_next = busy_reg;
        for (int r = 1; r < NREG; r++) begin
            if ((wb0_valid_i && (wb0_addr_i == AW'(r))) ||
                (wb1_valid_i && (wb1_addr_i == AW'(r)))) begin
                busy_next[r] = 1'b0;
            end
            if (issue_fire && (issue_rd_i == AW'(r))) begin
                busy_next[r] = 1'b1;
            end
        end
        busy_next[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy_o = busy_reg;

endmodule

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// Integer register file with two writeback ports, same-cycle forwarding,
// hardwired-zero register 0 and a per-register scoreboard.
// Ports:
//   clk_i  clock, all state updates on the rising edge
//   rst_i  asynchronous active-high reset (clears data, busy, collision)
//   bus    regfile_sb_if.slave: read ports, issue handshake, two writeback
//          ports and the registered collision pulse
// -----------------------------------------------------------------------------
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = NRD_DEF,
    localparam int AW  = $clog2(NREG)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    regfile_sb_if.slave  bus
);

    logic [XLEN-1:0] mem_reg [NREG];
    logic [NREG-1:0] busy;
    logic            collision_reg;
    logic            collision_next;

    genvar gi;

    // ---------------------------------------------------------------------
    // Storage. Entry 0 is reset to zero and never written afterwards; reads
    // of address 0 are also masked in the read mux. When both ports hit the
    // same register, the load (wb1) result is the one kept.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREG; r++) begin
                mem_reg[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (bus.wb1_valid_i && (bus.wb1_addr_i == AW'(r))) begin
                    mem_reg[r] <= bus.wb1_data_i;
                end else if (bus.wb0_valid_i && (bus.wb0_addr_i == AW'(r))) begin
                    mem_reg[r] <= bus.wb0_data_i;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Collision pulse: both ports to the same nonzero register.
    // ---------------------------------------------------------------------
    always_comb begin
        collision_next = bus.wb0_valid_i && bus.wb1_valid_i
                      && (bus.wb0_addr_i == bus.wb1_addr_i)
                      && (bus.wb0_addr_i != AW'(REG_ZERO));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            collision_reg <= 1'b0;
        end else begin
            collision_reg <= collision_next;
        end
    end

    assign bus.collision_o = collision_reg;

    // ---------------------------------------------------------------------
    // Scoreboard
    // ---------------------------------------------------------------------
    rf_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .issue_valid_i (bus.issue_valid_i),
        .issue_rd_i    (bus.issue_rd_i),
        .issue_ready_o (bus.issue_ready_o),
        .wb0_valid_i   (bus.wb0_valid_i),
        .wb0_addr_i    (bus.wb0_addr_i),
        .wb1_valid_i   (bus.wb1_valid_i),
        .wb1_addr_i    (bus.wb1_addr_i),
        .busy_o        (busy)
    );

    // ---------------------------------------------------------------------
    // Read ports with forwarding. A register being written this cycle is
    // reported not busy and returns the incoming data, so decode can consume
    // the result with zero extra latency.
    // ---------------------------------------------------------------------
    for (gi = 0; gi < NRD; gi++) begin : g_rd_port
        logic [AW-1:0]   addr;
        logic            wb0_hit;
        logic            wb1_hit;
        logic [XLEN-1:0] rd_data;

        assign addr    = bus.rs_addr_i[gi*AW +: AW];
        assign wb0_hit = bus.wb0_valid_i && (bus.wb0_addr_i == addr);
        assign wb1_hit = bus.wb1_valid_i && (bus.wb1_addr_i == addr);

        always_comb begin
            rd_data = mem_reg[addr];
            if (addr == AW'(REG_ZERO)) begin
                rd_data = '0;
            end else if (wb1_hit) begin
                rd_data = bus.wb1_data_i;
            end else if (wb0_hit) begin
                rd_data = bus.wb0_data_i;
            end
        end

        assign bus.rs_data_o[gi*XLEN +: XLEN] = rd_data;
        assign bus.rs_busy_o[gi] = busy[addr] && !(wb0_hit || wb1_hit);
    end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(32), .NREG(32), .NRD(2)) bus_a ();
    regfile_sb_if #(.XLEN(64), .NREG(16), .NRD(3)) bus_b ();

    regfile_sb #(.XLEN(32), .NREG(32), .NRD(2)) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a)
    );

    regfile_sb #(.XLEN(64), .NREG(16), .NRD(3)) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic  iv;   addr_t ird;
        logic  w0v;  addr_t w0a; data_t w0d;
        logic  w1v;  addr_t w1a; data_t w1d;
        addr_t ra0;  addr_t ra1;
        data_t ed0;  data_t ed1;
        logic  eb0;  logic  eb1;
        logic  erdy; logic  ecoll;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    task automatic check(input string name, input int idx,
                         input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic idle_a();
        bus_a.rs_addr_i     = '0;
        bus_a.issue_valid_i = 1'b0;
        bus_a.issue_rd_i    = '0;
        bus_a.wb0_valid_i   = 1'b0;
        bus_a.wb0_addr_i    = '0;
        bus_a.wb0_data_i    = '0;
        bus_a.wb1_valid_i   = 1'b0;
        bus_a.wb1_addr_i    = '0;
        bus_a.wb1_data_i    = '0;
    endtask

    task automatic idle_b();
        bus_b.rs_addr_i     = '0;
        bus_b.issue_valid_i = 1'b0;
        bus_b.issue_rd_i    = '0;
        bus_b.wb0_valid_i   = 1'b0;
        bus_b.wb0_addr_i    = '0;
        bus_b.wb0_data_i    = '0;
        bus_b.wb1_valid_i   = 1'b0;
        bus_b.wb1_addr_i    = '0;
        bus_b.wb1_data_i    = '0;
    endtask

    task automatic apply_a(input vec_t v);
        bus_a.issue_valid_i = v.iv;
        bus_a.issue_rd_i    = v.ird;
        bus_a.wb0_valid_i   = v.w0v;
        bus_a.wb0_addr_i    = v.w0a;
        bus_a.wb0_data_i    = v.w0d;
        bus_a.wb1_valid_i   = v.w1v;
        bus_a.wb1_addr_i    = v.w1a;
        bus_a.wb1_data_i    = v.w1d;
        bus_a.rs_addr_i     = {v.ra1, v.ra0};
    endtask

    initial begin
        // iv ird   w0v w0a  w0d           w1v w1a  w1d           ra0   ra1   ed0           ed1           eb0 eb1 erdy ecoll
        vecs = '{
            '{1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b0, 5'd5,  1'b1, 5'd5,  32'h0000_00AA, 1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'h0000_00AA, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b0, 5'd0,  1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'h0000_00AA, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b0, 5'd0,  1'b1, 5'd7,  32'h1111_1111, 1'b1, 5'd7,  32'h2222_2222, 5'd7,  5'd5,  32'h2222_2222, 32'h0000_00AA, 1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h2222_2222, 32'h2222_2222, 1'b0, 1'b0, 1'b1, 1'b1},
            '{1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  32'h2222_2222, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b1, 5'd3,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd3,  5'd3,  32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b1, 5'd3,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd3,  5'd5,  32'h0,        32'h0000_00AA, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b0, 5'd3,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd3,  5'd3,  32'h0,        32'h0,        1'b1, 1'b1, 1'b0, 1'b0},
            '{1'b0, 5'd3,  1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'h3333_3333, 5'd3,  5'd3,  32'h3333_3333, 32'h3333_3333, 1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b0, 5'd3,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd3,  5'd0,  32'h3333_3333, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b1, 5'd3,  1'b1, 5'd3,  32'h0000_0044, 1'b0, 5'd0,  32'h0,        5'd3,  5'd0,  32'h0000_0044, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b0, 5'd3,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd3,  5'd0,  32'h0000_0044, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b0, 5'd9,  1'b1, 5'd3,  32'h0000_0055, 1'b1, 5'd9,  32'h0000_0099, 5'd3,  5'd9,  32'h0000_0055, 32'h0000_0099, 1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b0, 5'd3,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd3,  5'd9,  32'h0000_0055, 32'h0000_0099, 1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b1, 5'd0,  1'b1, 5'd0,  32'hFFFF_FFFF, 1'b1, 5'd0,  32'h1234_5678, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd31, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b0, 5'd31, 1'b1, 5'd30, 32'h0000_CAFE, 1'b1, 5'd31, 32'hDEAD_BEEF, 5'd31, 5'd30, 32'hDEAD_BEEF, 32'h0000_CAFE, 1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b0, 5'd30, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd31, 5'd30, 32'hDEAD_BEEF, 32'h0000_CAFE, 1'b0, 1'b0, 1'b1, 1'b0}
        };

        idle_a();
        idle_b();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        // ---------------- table-driven sequence on the default instance
        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk);
            #1 apply_a(vecs[i]);
            #3;
            check("rd_data0", i, 64'(bus_a.rs_data_o[31:0]),  64'(vecs[i].ed0));
            check("rd_data1", i, 64'(bus_a.rs_data_o[63:32]), 64'(vecs[i].ed1));
            check("rd_busy0", i, 64'(bus_a.rs_busy_o[0]),     64'(vecs[i].eb0));
            check("rd_busy1", i, 64'(bus_a.rs_busy_o[1]),     64'(vecs[i].eb1));
            check("issue_rdy", i, 64'(bus_a.issue_ready_o),   64'(vecs[i].erdy));
            check("collision", i, 64'(bus_a.collision_o),     64'(vecs[i].ecoll));
            $display("vec %0d rs0=x%0d d0=%h b0=%b rs1=x%0d d1=%h b1=%b rdy=%b coll=%b",
                     i, vecs[i].ra0, bus_a.rs_data_o[31:0], bus_a.rs_busy_o[0],
                     vecs[i].ra1, bus_a.rs_data_o[63:32], bus_a.rs_busy_o[1],
                     bus_a.issue_ready_o, bus_a.collision_o);
        end

        // ---------------- mid-run asynchronous reset with work pending
        @(posedge clk);
        #1;
        idle_a();
        bus_a.wb0_valid_i = 1'b1; bus_a.wb0_addr_i = 5'd7;  bus_a.wb0_data_i = 32'h1111_1111;
        bus_a.wb1_valid_i = 1'b1; bus_a.wb1_addr_i = 5'd7;  bus_a.wb1_data_i = 32'h2222_2222;
        bus_a.issue_valid_i = 1'b1; bus_a.issue_rd_i = 5'd12;
        @(posedge clk);
        #1;
        idle_a();
        bus_a.wb0_valid_i = 1'b1; bus_a.wb0_addr_i = 5'd5; bus_a.wb0_data_i = 32'h0000_0077;
        bus_a.issue_valid_i = 1'b1; bus_a.issue_rd_i = 5'd13;
        bus_a.rs_addr_i = {5'd7, 5'd12};
        #1;
        check("pre_rst_coll",  0, 64'(bus_a.collision_o),     64'd1);
        check("pre_rst_busy",  0, 64'(bus_a.rs_busy_o[0]),    64'd1);
        check("pre_rst_data",  0, 64'(bus_a.rs_data_o[63:32]), 64'h2222_2222);
        $display("pre-reset x12 busy=%b x7=%h coll=%b",
                 bus_a.rs_busy_o[0], bus_a.rs_data_o[63:32], bus_a.collision_o);
        rst = 1'b1;
        #1;
        check("async_coll", 0, 64'(bus_a.collision_o),      64'd0);
        check("async_busy", 0, 64'(bus_a.rs_busy_o[0]),     64'd0);
        check("async_data", 0, 64'(bus_a.rs_data_o[63:32]), 64'd0);
        $display("async reset asserted coll=%b busy=%b x7=%h",
                 bus_a.collision_o, bus_a.rs_busy_o[0], bus_a.rs_data_o[63:32]);
        @(posedge clk);
        #2 idle_a();
        #2 rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            bus_a.rs_addr_i  = {5'(31 - a), 5'(a)};
            bus_a.issue_rd_i = 5'(a);
            #1;
            check("rst_data0", a, 64'(bus_a.rs_data_o[31:0]),  64'd0);
            check("rst_data1", a, 64'(bus_a.rs_data_o[63:32]), 64'd0);
            check("rst_busy0", a, 64'(bus_a.rs_busy_o[0]),     64'd0);
            check("rst_busy1", a, 64'(bus_a.rs_busy_o[1]),     64'd0);
            check("rst_ready", a, 64'(bus_a.issue_ready_o),    64'd1);
            $display("post-reset x%0d/x%0d d=%h/%h busy=%b rdy=%b", a, 31 - a,
                     bus_a.rs_data_o[31:0], bus_a.rs_data_o[63:32],
                     bus_a.rs_busy_o, bus_a.issue_ready_o);
        end
        idle_a();

        // ---------------- wide / small / three-port instance
        @(posedge clk);
        #1;
        idle_b();
        bus_b.wb0_valid_i = 1'b1; bus_b.wb0_addr_i = 4'd15; bus_b.wb0_data_i = 64'hFFFF_FFFF_FFFF_FFFF;
        bus_b.wb1_valid_i = 1'b1; bus_b.wb1_addr_i = 4'd2;  bus_b.wb1_data_i = 64'h0123_4567_89AB_CDEF;
        bus_b.rs_addr_i = {4'd0, 4'd2, 4'd15};
        #3;
        check("b_fwd_p0", 0, bus_b.rs_data_o[63:0],    64'hFFFF_FFFF_FFFF_FFFF);
        check("b_fwd_p1", 0, bus_b.rs_data_o[127:64],  64'h0123_4567_89AB_CDEF);
        check("b_fwd_p2", 0, bus_b.rs_data_o[191:128], 64'd0);
        $display("wide fwd p0=%h p1=%h p2=%h", bus_b.rs_data_o[63:0],
                 bus_b.rs_data_o[127:64], bus_b.rs_data_o[191:128]);

        @(posedge clk);
        #1;
        idle_b();
        bus_b.issue_valid_i = 1'b1; bus_b.issue_rd_i = 4'd15;
        bus_b.rs_addr_i = {4'd15, 4'd0, 4'd2};
        #3;
        check("b_arr_p0", 1, bus_b.rs_data_o[63:0],    64'h0123_4567_89AB_CDEF);
        check("b_arr_p1", 1, bus_b.rs_data_o[127:64],  64'd0);
        check("b_arr_p2", 1, bus_b.rs_data_o[191:128], 64'hFFFF_FFFF_FFFF_FFFF);
        check("b_ready",  1, 64'(bus_b.issue_ready_o), 64'd1);
        $display("wide array p0=%h p1=%h p2=%h rdy=%b", bus_b.rs_data_o[63:0],
                 bus_b.rs_data_o[127:64], bus_b.rs_data_o[191:128], bus_b.issue_ready_o);

        @(posedge clk);
        #1;
        idle_b();
        bus_b.wb0_valid_i = 1'b1; bus_b.wb0_addr_i = 4'd9; bus_b.wb0_data_i = 64'h0000_0005_0000_0005;
        bus_b.rs_addr_i = {4'd9, 4'd15, 4'd9};
        bus_b.issue_rd_i = 4'd15;
        #3;
        check("b_ind_p0",  2, bus_b.rs_data_o[63:0],    64'h0000_0005_0000_0005);
        check("b_ind_p1",  2, bus_b.rs_data_o[127:64],  64'hFFFF_FFFF_FFFF_FFFF);
        check("b_ind_p2",  2, bus_b.rs_data_o[191:128], 64'h0000_0005_0000_0005);
        check("b_busy_p1", 2, 64'(bus_b.rs_busy_o),     64'b010);
        check("b_stall",   2, 64'(bus_b.issue_ready_o), 64'd0);
        $display("wide indep p0=%h p1=%h p2=%h busy=%b rdy=%b", bus_b.rs_data_o[63:0],
                 bus_b.rs_data_o[127:64], bus_b.rs_data_o[191:128],
                 bus_b.rs_busy_o, bus_b.issue_ready_o);
        @(posedge clk);
        #1 idle_b();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised integer register file with a per-register scoreboard, for the in-order pipeline.
- Configurable data width, register count and read-port count.
- Two writeback ports: wb0 for single-cycle ALU results, wb1 for load / long-latency results.
- Same-cycle write-to-read forwarding, register 0 hardwired to zero.
- Busy bit per register, set at issue and cleared at writeback, so decode can detect RAW/WAW hazards and stall.

Parameters:
- XLEN, 32: data width in bits.
- NREG, 32: number of architectural registers; power of 2, at least 2.
- NRD, 2: number of read ports.
- AW, $clog2(NREG): register address width; localparam, not overridable.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- rs_addr_i  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
- rs_data_o  out  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN].
- rs_busy_o  out  NRD  1 = source register k has a pending write not yet visible.
- issue_valid_i  in  1  decode issues an instruction that writes issue_rd_i.
- issue_rd_i  in  AW  destination of the issuing instruction.
- issue_ready_o  out  1  issue_rd_i is free; issue is accepted only when high.
- wb0_valid_i  in  1  ALU writeback valid.
- wb0_addr_i  in  AW  ALU writeback destination.
- wb0_data_i  in  XLEN  ALU writeback data.
- wb1_valid_i  in  1  load writeback valid.
- wb1_addr_i  in  AW  load writeback destination.
- wb1_data_i  in  XLEN  load writeback data.
- collision_o  out  1  registered one-cycle pulse: both wb ports targeted the same nonzero register in the previous cycle.

Behaviour:
- Reset (asynchronous, while rst_i high):
  - all registers = 0, all busy bits = 0, collision_o = 0.
  - Reset during a pending write discards the write and clears the scoreboard.
- Register 0:
  - Reads always return 0 with busy = 0.
  - Writes are ignored, never set busy, never raise collision_o.
- Reads are combinational (0-cycle). Priority for read port k:
  - address 0 gives 0;
  - else wb1 valid and address match gives wb1_data_i;
  - else wb0 valid and address match gives wb0_data_i;
  - else array contents.
- rs_busy_o[k] = busy[rs_addr_k] and not (wb0 or wb1 valid to that address this cycle). A register being written this cycle reads as not busy, with forwarded data.
- Writes at the rising edge:
  - Each valid wb port writes its nonzero destination.
  - wb0 and wb1 to the same register in the same cycle: wb1 data is stored, and collision_o is 1 in the following cycle.
  - Writing a register whose busy bit is 0 is legal: data is stored, busy stays 0.
- Scoreboard:
  - issue_ready_o = (issue_rd_i == 0) or !busy[issue_rd_i] or a wb port writes issue_rd_i this cycle. It is combinational and independent of issue_valid_i.
  - Issue fires when issue_valid_i and issue_ready_o are both high. On fire with rd != 0, busy[rd] is set at the edge.
  - A valid wb to a register clears its busy bit at the edge.
  - Issue fire and wb to the same rd in the same cycle: set wins, so busy stays 1 for the new producer.
  - issue_valid_i with issue_ready_o low has no effect; decode holds the instruction.
- No internal pipeline registers other than the array, the busy vector and collision_o. Latency from write to visible is 0 cycles via forwarding, 1 cycle via the array.

Decomposition:
- Shared package regfile_pkg:
  - default XLEN and NREG localparams;
  - REG_ZERO constant (0);
  - addr_t / data_t typedefs sized from those defaults.
- Sub-module rf_scoreboard (busy vector, issue_ready_o, set/clear priority) keeps the hazard logic separately verifiable.
- The storage array and forwarding muxes stay in regfile_sb, generated per read port.

Test Plan:
- Reset then read: assert rst_i mid-run with writes pending, read every address on both ports → all data 0, rs_busy_o = 0, issue_ready_o = 1.
- Forwarding: wb0 writes x5 = 0x0000_00AA while port 0 reads x5 → rs_data_o[0] = 0xAA the same cycle, and from the array the next cycle. wb0 writing x0 = 0xFFFF_FFFF → x0 still reads 0.
- Dual-write collision: wb0 x7 = 0x1111_1111 and wb1 x7 = 0x2222_2222 in the same cycle → the forwarded read shows 0x2222_2222, the array holds 0x2222_2222, collision_o = 1 for exactly one cycle.
- Scoreboard RAW: issue rd = x3, then read x3 → rs_busy_o = 1. The wb1 x3 cycle → busy = 0 with forwarded data. The next cycle → busy = 0 from the array.
- WAW stall and set-wins:
  - x3 busy, issue x3 → issue_ready_o = 0 and busy unchanged.
  - Issue x3 in the same cycle wb0 writes x3 → issue_ready_o = 1 and busy[x3] = 1 after the edge.
- Parameter sweep: NREG = 16, XLEN = 64, NRD = 3 → all ports independently forward, and writes to x15 with 0xFFFF_FFFF_FFFF_FFFF read back intact.
